// File: rtl/tt_um_accelshark_psg_regsched.sv
// tt_um_accelshark_psg_regsched
// Host-write scheduler for the SharkPSG register file. Decodes the
// nibble-serial host protocol, queues {index, byte} writes in a small FIFO
// and commits them to the eight voice registers in a burst started by the
// I2S frame tick, so multi-register updates never land mid-frame.
//
// Parameters:
//   DEPTH            FIFO entries (power of two, 2..8)
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   ena              design enable; low holds all state and drops strobe edges
//   strobe           host write strobe (asynchronous, synchronized here)
//   address          1 = index write, 0 = data nibble write
//   data_high        selects high/low nibble for data writes
//   da[3:0]          host nibble
//   frame_tick       one-cycle pulse at the I2S frame boundary
//   voice*           the eight register outputs (registers 0..7)
//   fifo_full        FIFO holds DEPTH entries
//   overflow         sticky: a push was dropped
//   commit_busy      high while a commit burst is running
//
// Configuration macro SHARKPSG_IMMEDIATE_COMMIT_EN:
//   defined   - frame_tick unused, commit starts whenever the FIFO is non-empty
//   undefined - commit bursts start only on frame_tick
module tt_um_accelshark_psg_regsched #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       strobe,
  input  logic       address,
  input  logic       data_high,
  input  logic [3:0] da,
  input  logic       frame_tick,
  output logic [7:0] voice0123_enable,
  output logic [7:0] voice0123_octave,
  output logic [7:0] voice0_pitch,
  output logic [7:0] voice1_pitch,
  output logic [7:0] voice2_pitch,
  output logic [7:0] voice3_pitch,
  output logic [7:0] voice01_volume,
  output logic [7:0] voice23_volume,
  output logic       fifo_full,
  output logic       overflow,
  output logic       commit_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t          state;
  logic [2:0]      sync;       // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0]      index;
  logic [3:0]      hold_lo;
  logic [10:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [7:0]      regs [8];

  logic            strobe_ev;
  logic            byte_ev;
  logic            push;
  logic            pop;
  logic            commit_start;
  logic [10:0]     head;

  assign strobe_ev = ena & sync[1] & ~sync[2];
  assign byte_ev   = strobe_ev & ~address & data_high;
  assign pop       = ena & (state == COMMIT);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push      = byte_ev & ((count != CW'(DEPTH)) | pop);
  assign head      = mem[rd_ptr];

`ifdef SHARKPSG_IMMEDIATE_COMMIT_EN
  assign commit_start = (count != '0);
`else
  assign commit_start = frame_tick & (count != '0);
`endif

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  // Synchronizer keeps running while disabled so edges seen then are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync <= '0;
    else
      sync <= {sync[1:0], strobe};
  end

  // Queue storage needs no reset: count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {index, da, hold_lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      hold_lo  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < 8; i++)
        regs[i] <= '0;
    end else if (ena) begin
      if (strobe_ev && address) begin
        index <= da[2:0];
        if (da[3])
          overflow <= 1'b0;
      end else if (strobe_ev && !data_high) begin
        hold_lo <= da;
      end else if (byte_ev) begin
        index <= index + 3'd1;
        if (!push)
          overflow <= 1'b1;
      end

      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        regs[head[10:8]] <= head[7:0];
        rd_ptr           <= rd_ptr + 1'b1;
      end

      count <= count_next;

      case (state)
        IDLE:    if (commit_start) state <= COMMIT;
        COMMIT:  if (count == CW'(1) && !push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign voice0123_enable = regs[0];
  assign voice0123_octave = regs[1];
  assign voice0_pitch     = regs[2];
  assign voice1_pitch     = regs[3];
  assign voice2_pitch     = regs[4];
  assign voice3_pitch     = regs[5];
  assign voice01_volume   = regs[6];
  assign voice23_volume   = regs[7];
  assign fifo_full        = (count == CW'(DEPTH));
  assign commit_busy      = (state == COMMIT);

endmodule
